quic_dec_recon: RTL and testbench

- Reconstruction and neighbour stage of the QUIC decoder. Sits downstream of the Golomb decoder and the per-channel predictor.
- Each cycle it takes a mapped residual, or a run length, adds the residual to the predictor output, and writes the finished RGB pixel into a one-line buffer.
- It owns the raster position (row, column) and supplies the causal neighbours a, b, c, d per channel. These feed back into the predictor and the run detector.

---
 rtl/quic_dec_recon_if.sv | 59 +++++
 rtl/quic_dec_recon.sv | 233 +++++++++++++++++++++++
 tb/tb_quic_dec_recon.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/quic_dec_recon_if.sv
// Bus bundle for the QUIC reconstruction stage: frame control, residual/run
// inputs, predictor feed, raster position, causal neighbours and pixel output.
interface quic_dec_recon_if #(
   parameter int unsigned COL_W = 16
);
   // Frame control
   logic             start;
   logic [15:0]      img_width;
   logic [15:0]      img_height;

   // Residual and run requests
   logic             res_valid;
   logic [1:0]       res_chan;
   logic [7:0]       res_mapped;
   logic             run_valid;
   logic [15:0]      run_len;

   // Predictor outputs
   logic [7:0]       pix_r_pred;
   logic [7:0]       pix_g_pred;
   logic [7:0]       pix_b_pred;

   // Raster position
   logic [COL_W-1:0] row;
   logic [COL_W-1:0] column;

   // Causal neighbours: a=left, b=above, c=above-left, d=two-left
   logic [7:0]       pix_r_a, pix_r_b, pix_r_c, pix_r_d;
   logic [7:0]       pix_g_a, pix_g_b, pix_g_c, pix_g_d;
   logic [7:0]       pix_b_a, pix_b_b, pix_b_c, pix_b_d;

   // Reconstructed pixel and status
   logic             pix_out_valid;
   logic [23:0]      pix_out;
   logic             busy;
   logic             frame_done;

   modport master (
      output start, img_width, img_height,
      output res_valid, res_chan, res_mapped, run_valid, run_len,
      output pix_r_pred, pix_g_pred, pix_b_pred,
      input  row, column,
      input  pix_r_a, pix_r_b, pix_r_c, pix_r_d,
      input  pix_g_a, pix_g_b, pix_g_c, pix_g_d,
      input  pix_b_a, pix_b_b, pix_b_c, pix_b_d,
      input  pix_out_valid, pix_out, busy, frame_done
   );

   modport slave (
      input  start, img_width, img_height,
      input  res_valid, res_chan, res_mapped, run_valid, run_len,
      input  pix_r_pred, pix_g_pred, pix_b_pred,
      output row, column,
      output pix_r_a, pix_r_b, pix_r_c, pix_r_d,
      output pix_g_a, pix_g_b, pix_g_c, pix_g_d,
      output pix_b_a, pix_b_b, pix_b_c, pix_b_d,
      output pix_out_valid, pix_out, busy, frame_done
   );
endinterface

// File: rtl/quic_dec_recon.sv
// QUIC decoder reconstruction stage: unmaps residuals onto the predictor
// output, replays runs of the left neighbour, keeps the raster position and a
// one-line buffer, and supplies the causal neighbours a/b/c/d per channel.
module quic_dec_recon #(
   parameter int unsigned MAX_WIDTH = 1024,
   parameter int unsigned COL_W     = 16
) (
   input logic             clk,
   input logic             reset,
   quic_dec_recon_if.slave bus
);
   localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StPix, StRun} state_e;

   state_e           state_q, state_d;
   logic [COL_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [COL_W-1:0] width_q, width_d;
   logic [COL_W-1:0] height_q, height_d;
   logic [COL_W-1:0] run_cnt_q, run_cnt_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   // Neighbours and output pixel are packed {R,G,B}
   logic [23:0]      a_q, a_d;
   logic [23:0]      c_q, c_d;
   logic [23:0]      d_q, d_d;
   logic [23:0]      pix_q, pix_d;
   logic             pix_valid_q, pix_valid_d;
   logic             done_q, done_d;

   logic [23:0]      line_q [MAX_WIDTH];
   logic [23:0]      above;
   logic [7:0]       chan_pred;
   logic [7:0]       chan_val;
   logic [COL_W-1:0] run_req;
   logic [COL_W-1:0] run_room;
   logic [COL_W-1:0] run_n;
   logic             last_col;
   logic             last_row;
   logic             wr_en;
   logic [23:0]      wr_pix;

   // Undo the zig-zag map and add to the prediction, wrapping mod 256.
   function automatic logic [7:0] recon(input logic [7:0] pred, input logic [7:0] m);
      logic [8:0] mag;
      logic [8:0] sum;
      if (m[0]) begin
         mag = ({1'b0, m} + 9'd1) >> 1;
         sum = {1'b0, pred} - mag;
      end else begin
         mag = {2'b00, m[7:1]};
         sum = {1'b0, pred} + mag;
      end
      return sum[7:0];
   endfunction

   // Above neighbour for the current position; the previous row's pixel is
   // still in the line slot until this column is written. Row 0 has none.
   assign above = (row_q != '0) ? line_q[col_q[AW-1:0]] : 24'h0;

   assign last_col = (col_q == width_q - COL_W'(1));
   assign last_row = (row_q == height_q - COL_W'(1));

   // Per-channel predictor select and reconstruction.
   always_comb begin
      chan_pred = 8'h00;
      unique case (bus.res_chan)
         2'd0:    chan_pred = bus.pix_r_pred;
         2'd1:    chan_pred = bus.pix_g_pred;
         2'd2:    chan_pred = bus.pix_b_pred;
         default: chan_pred = 8'h00;
      endcase
      chan_val = recon(chan_pred, bus.res_mapped);
   end

   // Run length: zero counts as one, clipped to the end of the current row.
   always_comb begin
      run_req  = (bus.run_len == 16'h0) ? COL_W'(1) : COL_W'(bus.run_len);
      run_room = width_q - col_q;
      run_n    = (run_req < run_room) ? run_req : run_room;
   end

   // Next-state, pixel write, neighbour update and position advance.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      width_d     = width_q;
      height_d    = height_q;
      run_cnt_d   = run_cnt_q;
      r_d         = r_q;
      g_d         = g_q;
      a_d         = a_q;
      c_d         = c_q;
      d_d         = d_q;
      pix_d       = pix_q;
      pix_valid_d = 1'b0;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      wr_pix      = a_q;

      unique case (state_q)
         StIdle: begin
         end
         StPix: begin
            if (bus.res_valid) begin
               unique case (bus.res_chan)
                  2'd0: r_d = chan_val;
                  2'd1: g_d = chan_val;
                  2'd2: begin
                     wr_en  = 1'b1;
                     wr_pix = {r_q, g_q, chan_val};
                  end
                  default: begin
                  end
               endcase
            end
            // A completing B residual takes precedence over a run request.
            if (bus.run_valid && !(bus.res_valid && bus.res_chan == 2'd2)) begin
               run_cnt_d = run_n;
               state_d   = StRun;
            end
         end
         StRun: begin
            wr_en     = 1'b1;
            wr_pix    = a_q;
            run_cnt_d = run_cnt_q - COL_W'(1);
            if (run_cnt_q == COL_W'(1)) begin
               state_d = StPix;
            end
         end
         default: state_d = StIdle;
      endcase

      if (wr_en) begin
         pix_d       = wr_pix;
         pix_valid_d = 1'b1;
         d_d         = a_q;
         a_d         = wr_pix;
         c_d         = above;
         if (last_col) begin
            col_d = '0;
            row_d = row_q + COL_W'(1);
            a_d   = 24'h0;
            c_d   = 24'h0;
            d_d   = 24'h0;
            if (last_row) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end

      // start restarts the frame from any state.
      if (bus.start) begin
         state_d     = StPix;
         row_d       = '0;
         col_d       = '0;
         width_d     = COL_W'(bus.img_width);
         height_d    = COL_W'(bus.img_height);
         run_cnt_d   = '0;
         a_d         = 24'h0;
         c_d         = 24'h0;
         d_d         = 24'h0;
         pix_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         row_q       <= '0;
         col_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         run_cnt_q   <= '0;
         r_q         <= 8'h00;
         g_q         <= 8'h00;
         a_q         <= 24'h0;
         c_q         <= 24'h0;
         d_q         <= 24'h0;
         pix_q       <= 24'h0;
         pix_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         width_q     <= width_d;
         height_q    <= height_d;
         run_cnt_q   <= run_cnt_d;
         r_q         <= r_d;
         g_q         <= g_d;
         a_q         <= a_d;
         c_q         <= c_d;
         d_q         <= d_d;
         pix_q       <= pix_d;
         pix_valid_q <= pix_valid_d;
         done_q      <= done_d;
      end
   end

   // Line buffer write; contents need no reset since row 0 masks reads.
   always_ff @(posedge clk) begin
      if (wr_en && !bus.start && !reset) begin
         line_q[col_q[AW-1:0]] <= wr_pix;
      end
   end

   assign bus.row           = row_q;
   assign bus.column        = col_q;
   assign bus.pix_r_a       = a_q[23:16];
   assign bus.pix_g_a       = a_q[15:8];
   assign bus.pix_b_a       = a_q[7:0];
   assign bus.pix_r_b       = above[23:16];
   assign bus.pix_g_b       = above[15:8];
   assign bus.pix_b_b       = above[7:0];
   assign bus.pix_r_c       = c_q[23:16];
   assign bus.pix_g_c       = c_q[15:8];
   assign bus.pix_b_c       = c_q[7:0];
   assign bus.pix_r_d       = d_q[23:16];
   assign bus.pix_g_d       = d_q[15:8];
   assign bus.pix_b_d       = d_q[7:0];
   assign bus.pix_out_valid = pix_valid_q;
   assign bus.pix_out       = pix_q;
   assign bus.busy          = (state_q == StRun);
   assign bus.frame_done    = done_q;
endmodule

// File: tb/tb_quic_dec_recon.sv
// Scoreboard bench for quic_dec_recon: directed frames push expected pixels,
// a negedge monitor pops and compares every emitted pixel / frame_done.
module tb_quic_dec_recon;
   typedef struct packed {
      logic [23:0] pix;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;

   quic_dec_recon_if bus ();

   quic_dec_recon dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.pix_out_valid === 1'b1 || bus.frame_done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got pix %h done %b expected no output",
                     bus.pix_out, bus.frame_done);
         end else begin
            mon_e = sb.pop_front();
            check("pix_out", 32'(bus.pix_out), 32'(mon_e.pix));
            check("frame_done", 32'(bus.frame_done), 32'(mon_e.done));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
      bus.start      = 1'b1;
      bus.img_width  = w;
      bus.img_height = h;
      tick();
      bus.start = 1'b0;
   endtask

   // Three residual cycles R,G,B; optional run_valid alongside the B residual.
   task automatic send_pix(input logic [23:0] pred, input logic [23:0] m, input logic push,
                           input logic [23:0] exp, input logic done, input logic with_run);
      bus.pix_r_pred = pred[23:16];
      bus.pix_g_pred = pred[15:8];
      bus.pix_b_pred = pred[7:0];
      bus.res_valid  = 1'b1;
      bus.res_chan   = 2'd0;
      bus.res_mapped = m[23:16];
      tick();
      bus.res_chan   = 2'd1;
      bus.res_mapped = m[15:8];
      tick();
      bus.res_chan   = 2'd2;
      bus.res_mapped = m[7:0];
      if (with_run) begin
         bus.run_valid = 1'b1;
         bus.run_len   = 16'd3;
      end
      if (push) sb.push_back({exp, done});
      tick();
      bus.res_valid = 1'b0;
      bus.run_valid = 1'b0;
   endtask

   task automatic gray(input logic [7:0] v, input logic done);
      send_pix({v, v, v}, 24'h0, 1'b1, {v, v, v}, done, 1'b0);
   endtask

   task automatic check_nb(input string name, input logic [23:0] ea, input logic [23:0] eb,
                           input logic [23:0] ec, input logic [23:0] ed);
      check({name, "_a"}, 32'({bus.pix_r_a, bus.pix_g_a, bus.pix_b_a}), 32'(ea));
      check({name, "_b"}, 32'({bus.pix_r_b, bus.pix_g_b, bus.pix_b_b}), 32'(eb));
      check({name, "_c"}, 32'({bus.pix_r_c, bus.pix_g_c, bus.pix_b_c}), 32'(ec));
      check({name, "_d"}, 32'({bus.pix_r_d, bus.pix_g_d, bus.pix_b_d}), 32'(ed));
   endtask

   task automatic run_and_count(input logic [15:0] len, input int n, input logic [23:0] px,
                                input string name);
      int cnt;
      for (int i = 0; i < n; i++) sb.push_back({px, 1'b0});
      bus.run_valid = 1'b1;
      bus.run_len   = len;
      tick();
      bus.run_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.busy === 1'b1) cnt++;
         tick();
      end
      check(name, 32'(cnt), 32'(n));
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_row"}, 32'(bus.row), 32'h0);
      check({name, "_col"}, 32'(bus.column), 32'h0);
      check({name, "_pix"}, 32'(bus.pix_out), 32'h0);
      check({name, "_valid"}, 32'(bus.pix_out_valid), 32'h0);
      check({name, "_busy"}, 32'(bus.busy), 32'h0);
      check({name, "_done"}, 32'(bus.frame_done), 32'h0);
      check_nb(name, 24'h0, 24'h0, 24'h0, 24'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.img_width  = 16'd0;
      bus.img_height = 16'd0;
      bus.res_valid  = 1'b0;
      bus.res_chan   = 2'd0;
      bus.res_mapped = 8'h00;
      bus.pix_r_pred = 8'h00;
      bus.pix_g_pred = 8'h00;
      bus.pix_b_pred = 8'h00;
      bus.run_valid  = 1'b0;
      bus.run_len    = 16'd0;
      tick();
      tick();
      reset = 1'b0;
      check_idle_outputs("reset");

      // 1x1 frame: R=100+2, G=100-2, B=100
      start_frame(16'd1, 16'd1);
      send_pix(24'h646464, 24'h040300, 1'b1, 24'h666264, 1'b1, 1'b0);
      check("one_busy", 32'(bus.busy), 32'h0);
      // Back in idle: these residuals must produce nothing
      send_pix(24'h646464, 24'h040300, 1'b0, 24'h0, 1'b0, 1'b0);
      tick();
      check("idle_ignore_valid", 32'(bus.pix_out_valid), 32'h0);

      // Wrap arithmetic on a 2x1 frame
      start_frame(16'd2, 16'd1);
      send_pix(24'hFA0300, 24'h140900, 1'b1, 24'h04FE00, 1'b0, 1'b0);
      check("wrap_col", 32'(bus.column), 32'h1);
      check_nb("wrap", 24'h04FE00, 24'h0, 24'h0, 24'h0);
      send_pix(24'h00C801, 24'hFFFE01, 1'b1, 24'h804700, 1'b1, 1'b0);

      // 4x2 gray frame neighbours
      start_frame(16'd4, 16'd2);
      gray(8'd10, 1'b0);
      check_nb("r0c1", 24'h0A0A0A, 24'h0, 24'h0, 24'h0);
      gray(8'd20, 1'b0);
      gray(8'd30, 1'b0);
      gray(8'd40, 1'b0);
      check("r1c0_row", 32'(bus.row), 32'h1);
      check("r1c0_col", 32'(bus.column), 32'h0);
      check_nb("r1c0", 24'h0, 24'h0A0A0A, 24'h0, 24'h0);
      gray(8'd50, 1'b0);
      check_nb("r1c1", 24'h323232, 24'h141414, 24'h0A0A0A, 24'h0);
      gray(8'd60, 1'b0);
      check_nb("r1c2", 24'h3C3C3C, 24'h1E1E1E, 24'h141414, 24'h323232);
      gray(8'd70, 1'b0);
      gray(8'd80, 1'b1);

      // 10x2 frame with runs
      start_frame(16'd10, 16'd2);
      gray(8'd1, 1'b0);
      gray(8'd2, 1'b0);
      send_pix(24'h123456, 24'h0, 1'b1, 24'h123456, 1'b0, 1'b0);
      check("run4_col_before", 32'(bus.column), 32'h3);
      check_nb("c3", 24'h123456, 24'h0, 24'h0, 24'h020202);
      run_and_count(16'd4, 4, 24'h123456, "run4_busy");
      check("run4_col_after", 32'(bus.column), 32'h7);
      send_pix(24'h010203, 24'h0, 1'b1, 24'h010203, 1'b0, 1'b0);
      check("clip_col_before", 32'(bus.column), 32'h8);
      run_and_count(16'd5, 2, 24'h010203, "clip_busy");
      check("clip_row", 32'(bus.row), 32'h1);
      check("clip_col", 32'(bus.column), 32'h0);
      check_nb("clip", 24'h0, 24'h010101, 24'h0, 24'h0);
      run_and_count(16'd0, 1, 24'h000000, "len0_busy");
      check("len0_col", 32'(bus.column), 32'h1);
      check_nb("len0", 24'h0, 24'h020202, 24'h010101, 24'h0);
      // Run request coinciding with the B residual is dropped
      send_pix(24'h0A0B0C, 24'h0, 1'b1, 24'h0A0B0C, 1'b0, 1'b1);
      check("bwin_busy", 32'(bus.busy), 32'h0);
      check("bwin_col", 32'(bus.column), 32'h2);
      tick();
      check("bwin_busy2", 32'(bus.busy), 32'h0);

      // Reset in the middle of a run
      bus.run_valid = 1'b1;
      bus.run_len   = 16'd6;
      tick();
      bus.run_valid = 1'b0;
      check("pre_reset_busy", 32'(bus.busy), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("midrun_reset");
      send_pix(24'h111111, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
      tick();
      tick();
      check("post_reset_valid", 32'(bus.pix_out_valid), 32'h0);
      check("post_reset_col", 32'(bus.column), 32'h0);
      check("post_reset_busy", 32'(bus.busy), 32'h0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("scoreboard_drain", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
